// File: rtl/ai_accel_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ai_accel_pkg : shared state/status encodings and job metadata layout
// Revision 1.0
// ---------------------------------------------------------------------------
package ai_accel_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_LOAD     = 3'd1;
   localparam logic [2:0] ST_ISSUE    = 3'd2;
   localparam logic [2:0] ST_WAIT     = 3'd3;
   localparam logic [2:0] ST_COMPLETE = 3'd4;

   localparam logic [1:0] STAT_OK      = 2'b00;
   localparam logic [1:0] STAT_EMPTY   = 2'b01;
   localparam logic [1:0] STAT_TIMEOUT = 2'b10;

   typedef struct packed {
      logic [15:0] count;
      logic [7:0]  channels;
      logic [2:0]  data_type;
      logic [3:0]  id;
   } job_meta_t;

   localparam int unsigned JOB_META_W = $bits(job_meta_t);

   // A channel count of zero behaves as a single channel.
   function automatic logic [7:0] last_chan(input logic [7:0] ch);
      return (ch == 8'd0) ? 8'd0 : ch - 8'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ai_job_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ai_job_fifo : in-order job queue with first-word-fall-through head
// Revision 1.0
// ---------------------------------------------------------------------------
module ai_job_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      occ_q, occ_d;
   logic             do_push, do_pop;

   assign full    = (occ_q == (AW+1)'(DEPTH));
   assign empty   = (occ_q == '0);
   assign rd_data = mem_q[rd_ptr_q];

   // Depth is a power of two, so pointers wrap by natural overflow.
   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      occ_d    = occ_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/ai_bn_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ai_bn_scheduler : queues batchnorm jobs and issues them element by element
// Revision 1.0
// ---------------------------------------------------------------------------
module ai_bn_scheduler
   import ai_accel_pkg::*;
#(
   parameter int unsigned XLEN       = 64,
   parameter int unsigned ELEM_BYTES = 4,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [XLEN-1:0] cmd_input_addr,
   input  logic [XLEN-1:0] cmd_scale_addr,
   input  logic [XLEN-1:0] cmd_bias_addr,
   input  logic [15:0]     cmd_count,
   input  logic [7:0]      cmd_channels,
   input  logic [2:0]      cmd_data_type,
   input  logic [3:0]      cmd_id,
   output logic            bn_enable,
   output logic [2:0]      bn_data_type,
   output logic [XLEN-1:0] bn_input_addr,
   output logic [XLEN-1:0] bn_scale_addr,
   output logic [XLEN-1:0] bn_bias_addr,
   input  logic            bn_valid,
   output logic            done_valid,
   output logic [3:0]      done_id,
   output logic [1:0]      done_status,
   output logic [15:0]     done_count,
   output logic            busy
);

   localparam int unsigned FW         = 3*XLEN + JOB_META_W;
   localparam int unsigned TW         = $clog2(TIMEOUT + 1);
   localparam logic [XLEN-1:0] STRIDE = XLEN'(ELEM_BYTES);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   logic [FW-1:0]   fifo_wr, fifo_rd;
   logic            fifo_full, fifo_empty, fifo_pop;
   job_meta_t       head_meta;
   logic [XLEN-1:0] head_input, head_scale, head_bias;

   logic [2:0]      state_q, state_d;
   logic [15:0]     count_q, count_d;
   logic [7:0]      chan_last_q, chan_last_d;
   logic [3:0]      job_id_q, job_id_d;
   logic [XLEN-1:0] scale_base_q, scale_base_d;
   logic [XLEN-1:0] bias_base_q, bias_base_d;
   logic [15:0]     elem_idx_q, elem_idx_d, elem_next;
   logic [7:0]      chan_idx_q, chan_idx_d;
   logic [TW-1:0]   timer_q, timer_d;

   logic            bn_enable_q, bn_enable_d;
   logic [2:0]      bn_data_type_q, bn_data_type_d;
   logic [XLEN-1:0] bn_input_addr_q, bn_input_addr_d;
   logic [XLEN-1:0] bn_scale_addr_q, bn_scale_addr_d;
   logic [XLEN-1:0] bn_bias_addr_q, bn_bias_addr_d;
   logic            done_valid_q, done_valid_d;
   logic [3:0]      done_id_q, done_id_d;
   logic [1:0]      done_status_q, done_status_d;
   logic [15:0]     done_count_q, done_count_d;

   assign fifo_wr = {cmd_input_addr, cmd_scale_addr, cmd_bias_addr,
                     cmd_count, cmd_channels, cmd_data_type, cmd_id};
   assign fifo_pop   = (state_q == ST_LOAD);
   assign head_input = fifo_rd[FW-1 -: XLEN];
   assign head_scale = fifo_rd[FW-XLEN-1 -: XLEN];
   assign head_bias  = fifo_rd[JOB_META_W +: XLEN];
   assign head_meta  = job_meta_t'(fifo_rd[JOB_META_W-1:0]);

   ai_job_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push    (cmd_valid),
      .wr_data (fifo_wr),
      .pop     (fifo_pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign cmd_ready = !fifo_full;
   assign busy      = (state_q != ST_IDLE) || !fifo_empty;

   always_comb begin
      state_d         = state_q;
      count_d         = count_q;
      chan_last_d     = chan_last_q;
      job_id_d        = job_id_q;
      scale_base_d    = scale_base_q;
      bias_base_d     = bias_base_q;
      elem_idx_d      = elem_idx_q;
      chan_idx_d      = chan_idx_q;
      timer_d         = timer_q;
      bn_enable_d     = 1'b0;
      bn_data_type_d  = bn_data_type_q;
      bn_input_addr_d = bn_input_addr_q;
      bn_scale_addr_d = bn_scale_addr_q;
      bn_bias_addr_d  = bn_bias_addr_q;
      done_valid_d    = 1'b0;
      done_id_d       = done_id_q;
      done_status_d   = done_status_q;
      done_count_d    = done_count_q;
      elem_next       = elem_idx_q + 16'd1;

      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            count_d         = head_meta.count;
            chan_last_d     = last_chan(head_meta.channels);
            job_id_d        = head_meta.id;
            bn_data_type_d  = head_meta.data_type;
            elem_idx_d      = '0;
            chan_idx_d      = '0;
            timer_d         = '0;
            scale_base_d    = head_scale;
            bias_base_d     = head_bias;
            bn_input_addr_d = head_input;
            bn_scale_addr_d = head_scale;
            bn_bias_addr_d  = head_bias;
            if (head_meta.count == 16'd0) begin
               state_d       = ST_COMPLETE;
               done_valid_d  = 1'b1;
               done_id_d     = head_meta.id;
               done_status_d = STAT_EMPTY;
               done_count_d  = '0;
            end else begin
               state_d     = ST_ISSUE;
               bn_enable_d = 1'b1;
            end
         end
         ST_ISSUE: begin
            timer_d = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A completion on the final timeout cycle still wins.
            if (bn_valid) begin
               elem_idx_d      = elem_next;
               bn_input_addr_d = bn_input_addr_q + STRIDE;
               if (chan_idx_q == chan_last_q) begin
                  chan_idx_d      = '0;
                  bn_scale_addr_d = scale_base_q;
                  bn_bias_addr_d  = bias_base_q;
               end else begin
                  chan_idx_d      = chan_idx_q + 8'd1;
                  bn_scale_addr_d = bn_scale_addr_q + STRIDE;
                  bn_bias_addr_d  = bn_bias_addr_q + STRIDE;
               end
               if (elem_next == count_q) begin
                  state_d       = ST_COMPLETE;
                  done_valid_d  = 1'b1;
                  done_id_d     = job_id_q;
                  done_status_d = STAT_OK;
                  done_count_d  = elem_next;
               end else begin
                  state_d     = ST_ISSUE;
                  bn_enable_d = 1'b1;
               end
            end else if (timer_q == TIMER_LAST) begin
               state_d       = ST_COMPLETE;
               done_valid_d  = 1'b1;
               done_id_d     = job_id_q;
               done_status_d = STAT_TIMEOUT;
               done_count_d  = elem_idx_q;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_COMPLETE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= ST_IDLE;
         count_q         <= '0;
         chan_last_q     <= '0;
         job_id_q        <= '0;
         scale_base_q    <= '0;
         bias_base_q     <= '0;
         elem_idx_q      <= '0;
         chan_idx_q      <= '0;
         timer_q         <= '0;
         bn_enable_q     <= 1'b0;
         bn_data_type_q  <= '0;
         bn_input_addr_q <= '0;
         bn_scale_addr_q <= '0;
         bn_bias_addr_q  <= '0;
         done_valid_q    <= 1'b0;
         done_id_q       <= '0;
         done_status_q   <= '0;
         done_count_q    <= '0;
      end else begin
         state_q         <= state_d;
         count_q         <= count_d;
         chan_last_q     <= chan_last_d;
         job_id_q        <= job_id_d;
         scale_base_q    <= scale_base_d;
         bias_base_q     <= bias_base_d;
         elem_idx_q      <= elem_idx_d;
         chan_idx_q      <= chan_idx_d;
         timer_q         <= timer_d;
         bn_enable_q     <= bn_enable_d;
         bn_data_type_q  <= bn_data_type_d;
         bn_input_addr_q <= bn_input_addr_d;
         bn_scale_addr_q <= bn_scale_addr_d;
         bn_bias_addr_q  <= bn_bias_addr_d;
         done_valid_q    <= done_valid_d;
         done_id_q       <= done_id_d;
         done_status_q   <= done_status_d;
         done_count_q    <= done_count_d;
      end
   end

   assign bn_enable     = bn_enable_q;
   assign bn_data_type  = bn_data_type_q;
   assign bn_input_addr = bn_input_addr_q;
   assign bn_scale_addr = bn_scale_addr_q;
   assign bn_bias_addr  = bn_bias_addr_q;
   assign done_valid    = done_valid_q;
   assign done_id       = done_id_q;
   assign done_status   = done_status_q;
   assign done_count    = done_count_q;

endmodule
`default_nettype wire

// File: tb/tb_ai_bn_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ai_bn_scheduler : directed self-checking bench for ai_bn_scheduler
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_ai_bn_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [63:0] cmd_input_addr, cmd_scale_addr, cmd_bias_addr;
   logic [15:0] cmd_count;
   logic [7:0]  cmd_channels;
   logic [2:0]  cmd_data_type;
   logic [3:0]  cmd_id;
   logic        bn_enable;
   logic [2:0]  bn_data_type;
   logic [63:0] bn_input_addr, bn_scale_addr, bn_bias_addr;
   logic        bn_valid;
   logic        done_valid;
   logic [3:0]  done_id;
   logic [1:0]  done_status;
   logic [15:0] done_count;
   logic        busy;

   ai_bn_scheduler #(
      .XLEN       (64),
      .ELEM_BYTES (4),
      .FIFO_DEPTH (4),
      .TIMEOUT    (16)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_input_addr (cmd_input_addr),
      .cmd_scale_addr (cmd_scale_addr),
      .cmd_bias_addr  (cmd_bias_addr),
      .cmd_count      (cmd_count),
      .cmd_channels   (cmd_channels),
      .cmd_data_type  (cmd_data_type),
      .cmd_id         (cmd_id),
      .bn_enable      (bn_enable),
      .bn_data_type   (bn_data_type),
      .bn_input_addr  (bn_input_addr),
      .bn_scale_addr  (bn_scale_addr),
      .bn_bias_addr   (bn_bias_addr),
      .bn_valid       (bn_valid),
      .done_valid     (done_valid),
      .done_id        (done_id),
      .done_status    (done_status),
      .done_count     (done_count),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          resp_lat = 0;
   int          resp_cnt = 0;

   int          en_cyc[$];
   logic [63:0] en_in[$], en_sc[$], en_bi[$];
   logic [3:0]  d_id[$];
   logic [1:0]  d_st[$];
   logic [15:0] d_cnt[$];
   int          d_cyc[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Unit model: one bn_valid pulse resp_lat cycles after each bn_enable.
   initial begin
      bn_valid = 1'b0;
      forever begin
         @(negedge clk);
         bn_valid = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) bn_valid = 1'b1;
         end
         if (bn_enable && resp_lat > 0) resp_cnt = resp_lat;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (bn_enable) begin
            en_cyc.push_back(cyc);
            en_in.push_back(bn_input_addr);
            en_sc.push_back(bn_scale_addr);
            en_bi.push_back(bn_bias_addr);
         end
         if (done_valid) begin
            d_id.push_back(done_id);
            d_st.push_back(done_status);
            d_cnt.push_back(done_count);
            d_cyc.push_back(cyc);
         end
      end
   end

   task automatic clear_logs();
      en_cyc.delete(); en_in.delete(); en_sc.delete(); en_bi.delete();
      d_id.delete(); d_st.delete(); d_cnt.delete(); d_cyc.delete();
   endtask

   task automatic push_job(input logic [63:0] ia, input logic [63:0] sa, input logic [63:0] ba,
                           input logic [15:0] cnt, input logic [7:0] ch, input logic [3:0] id,
                           output int pc, output logic fr);
      int k = 0;
      cmd_valid      = 1'b1;
      cmd_input_addr = ia;
      cmd_scale_addr = sa;
      cmd_bias_addr  = ba;
      cmd_count      = cnt;
      cmd_channels   = ch;
      cmd_data_type  = 3'd2;
      cmd_id         = id;
      fr = cmd_ready;
      while (!cmd_ready && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!cmd_ready) check("push_budget", 64'd0, 64'd1);
      pc = cyc;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_dones(input int n, input int budget);
      int k = 0;
      while (d_id.size() < n && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      if (d_id.size() < n) check("wait_done_budget", 64'(d_id.size()), 64'(n));
   endtask

   task automatic wait_ens(input int n, input int budget);
      int k = 0;
      while (en_cyc.size() < n && k < budget) begin
         @(negedge clk); #1;
         k++;
      end
      if (en_cyc.size() < n) check("wait_en_budget", 64'(en_cyc.size()), 64'(n));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running, expected finished");
      $fatal(1);
   end

   initial begin
      int   pc;
      logic fr;
      int   nd;
      cmd_valid = 0; cmd_input_addr = 0; cmd_scale_addr = 0; cmd_bias_addr = 0;
      cmd_count = 0; cmd_channels = 0; cmd_data_type = 0; cmd_id = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_bn_enable", 64'(bn_enable), 64'd0);
      check("rst_done_valid", 64'(done_valid), 64'd0);
      check("rst_input_addr", bn_input_addr, 64'd0);
      check("rst_done_fields", {done_id, done_status, done_count}, 64'd0);

      rst_n = 1'b1;
      @(negedge clk);

      // Three elements over two channels, unit latency 5.
      clear_logs();
      resp_lat = 5;
      push_job(64'h1000, 64'h2000, 64'h3000, 16'd3, 8'd2, 4'd1, pc, fr);
      wait_dones(1, 200);
      check("t1_en_count", 64'(en_cyc.size()), 64'd3);
      check("t1_in0", en_in[0], 64'h1000);
      check("t1_in1", en_in[1], 64'h1004);
      check("t1_in2", en_in[2], 64'h1008);
      check("t1_sc0", en_sc[0], 64'h2000);
      check("t1_sc1", en_sc[1], 64'h2004);
      check("t1_sc2", en_sc[2], 64'h2000);
      check("t1_bi1", en_bi[1], 64'h3004);
      check("t1_bi2", en_bi[2], 64'h3000);
      check("t1_first_en_lat", 64'(en_cyc[0] - pc), 64'd3);
      check("t1_en_spacing", 64'(en_cyc[1] - en_cyc[0]), 64'd6);
      check("t1_done_lat", 64'(d_cyc[0] - en_cyc[2]), 64'd6);
      check("t1_done_id", 64'(d_id[0]), 64'd1);
      check("t1_done_status", 64'(d_st[0]), 64'd0);
      check("t1_done_count", 64'(d_cnt[0]), 64'd3);
      check("t1_data_type", 64'(bn_data_type), 64'd2);
      repeat (3) @(negedge clk);
      check("t1_idle_busy", 64'(busy), 64'd0);

      // Empty job.
      clear_logs();
      push_job(64'h5000, 64'h6000, 64'h7000, 16'd0, 8'd0, 4'd5, pc, fr);
      wait_dones(1, 50);
      repeat (3) @(negedge clk);
      check("t2_en_count", 64'(en_cyc.size()), 64'd0);
      check("t2_done_id", 64'(d_id[0]), 64'd5);
      check("t2_done_status", 64'(d_st[0]), 64'd1);
      check("t2_done_count", 64'(d_cnt[0]), 64'd0);

      // Unit never answers.
      clear_logs();
      resp_lat = 0;
      push_job(64'h100, 64'h200, 64'h300, 16'd2, 8'd1, 4'd6, pc, fr);
      wait_dones(1, 100);
      repeat (3) @(negedge clk);
      check("t3_en_count", 64'(en_cyc.size()), 64'd1);
      check("t3_done_status", 64'(d_st[0]), 64'd2);
      check("t3_done_count", 64'(d_cnt[0]), 64'd0);
      check("t3_done_lat", 64'(d_cyc[0] - en_cyc[0]), 64'd17);

      // Response lands on the last timeout cycle.
      clear_logs();
      resp_lat = 16;
      push_job(64'h100, 64'h200, 64'h300, 16'd2, 8'd1, 4'd7, pc, fr);
      wait_dones(1, 200);
      check("t4_en_count", 64'(en_cyc.size()), 64'd2);
      check("t4_en_spacing", 64'(en_cyc[1] - en_cyc[0]), 64'd17);
      check("t4_done_status", 64'(d_st[0]), 64'd0);
      check("t4_done_count", 64'(d_cnt[0]), 64'd2);
      repeat (3) @(negedge clk);

      // Fill the queue behind an active job.
      clear_logs();
      resp_lat = 8;
      push_job(64'h0, 64'h0, 64'h0, 16'd1, 8'd1, 4'd1, pc, fr);
      wait_ens(1, 50);
      for (int j = 2; j <= 6; j++) begin
         push_job(64'(j * 64'h100), 64'h0, 64'h0, 16'd1, 8'd1, 4'(j), pc, fr);
         check($sformatf("t5_ready_push%0d", j), 64'(fr), (j <= 5) ? 64'd1 : 64'd0);
      end
      wait_dones(6, 600);
      for (int j = 0; j < 6; j++) begin
         check($sformatf("t5_done_id%0d", j), 64'(d_id[j]), 64'(j + 1));
         check($sformatf("t5_done_st%0d", j), 64'(d_st[j]), 64'd0);
      end
      repeat (3) @(negedge clk);
      check("t5_idle_busy", 64'(busy), 64'd0);

      // Reset during the wait phase of job 2 of 3.
      clear_logs();
      resp_lat = 4;
      push_job(64'h1000, 64'h2000, 64'h3000, 16'd2, 8'd1, 4'd8, pc, fr);
      push_job(64'h4000, 64'h5000, 64'h6000, 16'd2, 8'd1, 4'd9, pc, fr);
      push_job(64'h7000, 64'h8000, 64'h9000, 16'd2, 8'd1, 4'd10, pc, fr);
      wait_ens(3, 200);
      @(negedge clk); #1;
      check("t6_pre_dones", 64'(d_id.size()), 64'd1);
      nd = d_id.size();
      #1;
      rst_n    = 1'b0;
      resp_lat = 0;
      resp_cnt = 0;
      #1;
      check("t6_rst_bn_enable", 64'(bn_enable), 64'd0);
      check("t6_rst_done_valid", 64'(done_valid), 64'd0);
      check("t6_rst_busy", 64'(busy), 64'd0);
      check("t6_rst_cmd_ready", 64'(cmd_ready), 64'd1);
      check("t6_rst_input_addr", bn_input_addr, 64'd0);
      check("t6_rst_scale_addr", bn_scale_addr, 64'd0);
      check("t6_rst_bias_addr", bn_bias_addr, 64'd0);
      check("t6_rst_done_fields", {done_id, done_status, done_count}, 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      #1;
      check("t6_no_done", 64'(d_id.size()), 64'(nd));
      check("t6_no_enable", 64'(en_cyc.size()), 64'd3);
      check("t6_post_busy", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ai_bn_scheduler.md
AI_BN_SCHEDULER -- requirements
Module: ai_bn_scheduler

Interface
REQ-001 SHALL have parameter XLEN, default 64, address width.
REQ-002 SHALL have parameter ELEM_BYTES, default 4, byte stride per element.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, job queue entries (power of 2, >=2).
REQ-004 SHALL have parameter TIMEOUT, default 1024, max cycles waiting for bn_valid.
REQ-005 SHALL have ports, in this order:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  job offered
cmd_ready  out  1  queue can accept
cmd_input_addr  in  XLEN  tensor base
cmd_scale_addr  in  XLEN  per-channel scale base
cmd_bias_addr  in  XLEN  per-channel bias base
cmd_count  in  16  element count
cmd_channels  in  8  channel count (0 treated as 1)
cmd_data_type  in  3  passed to unit
cmd_id  in  4  job tag
bn_enable  out  1  one-cycle start pulse to batchnorm unit
bn_data_type  out  3  current job data type
bn_input_addr  out  XLEN  element address
bn_scale_addr  out  XLEN  channel scale address
bn_bias_addr  out  XLEN  channel bias address
bn_valid  in  1  one-cycle element-complete pulse from unit
done_valid  out  1  one-cycle job-complete pulse
done_id  out  4  tag of completed job
done_status  out  2  00 OK, 01 EMPTY, 10 TIMEOUT
done_count  out  16  elements completed
busy  out  1  job active or queue non-empty

Function
REQ-006 SHALL accept a job on a cycle with cmd_valid and cmd_ready both high; cmd_ready = queue not full.
REQ-007 SHALL store jobs in an in-order FIFO of FIFO_DEPTH entries; accept while full is impossible by REQ-006.
REQ-008 SHALL implement states IDLE, LOAD, ISSUE, WAIT, COMPLETE.
REQ-009 IDLE -> LOAD when FIFO non-empty; LOAD pops head into job registers, clears elem_idx, chan_idx, timer.
REQ-010 LOAD -> COMPLETE with status EMPTY, count 0, if cmd_count was 0; else LOAD -> ISSUE.
REQ-011 ISSUE SHALL assert bn_enable for exactly one cycle, then -> WAIT.
REQ-012 bn_input_addr SHALL equal input_addr + elem_idx*ELEM_BYTES; scale/bias addrs base + chan_idx*ELEM_BYTES; all truncated to XLEN, held stable from ISSUE through WAIT exit.
REQ-013 WAIT on bn_valid: elem_idx+1; chan_idx+1, wrapping to 0 when chan_idx = channels-1; -> COMPLETE (OK) if elem_idx+1 = count, else -> ISSUE.
REQ-014 WAIT SHALL increment timer each cycle without bn_valid; at timer = TIMEOUT-1 -> COMPLETE with TIMEOUT, count = elem_idx; bn_valid in that same cycle takes priority over timeout.
REQ-015 Timer SHALL clear on each ISSUE.
REQ-016 COMPLETE SHALL pulse done_valid one cycle with id/status/count, then -> IDLE.
REQ-017 bn_valid outside WAIT SHALL be ignored.
REQ-018 A push and pop in the same cycle SHALL both occur; occupancy unchanged.
REQ-019 Minimum per-element overhead: ISSUE-to-ISSUE = 2 cycles plus unit latency; pop-to-first-bn_enable = 1 cycle.
REQ-020 busy SHALL be high whenever state != IDLE or FIFO non-empty.
REQ-021 Outputs bn_* and done_* SHALL be registered.

Reset
REQ-022 On rst_n low, asynchronously: state IDLE, FIFO empty, cmd_ready 1, bn_enable 0, done_valid 0, busy 0, all address/id/status/count outputs 0.
REQ-023 Reset mid-job SHALL discard active job and queue with no done_valid.

Structure
REQ-024 Status encodings and state enum SHALL live in shared package ai_accel_pkg.
REQ-025 Job FIFO SHALL be sub-module ai_job_fifo (parameterised width/depth, push/pop/full/empty).

Verification
REQ-026 Job count=3, channels=2, input 0x1000, scale 0x2000, bias 0x3000, unit valid 5 cycles after enable -> input addrs 0x1000/0x1004/0x1008, scale 0x2000/0x2004/0x2000, done OK count 3.
REQ-027 Job count=0 id=5 -> no bn_enable, done_valid with id 5, EMPTY, count 0.
REQ-028 Count=2, unit never responds, TIMEOUT=16 -> one bn_enable, done TIMEOUT count 0, 16 cycles after ISSUE exit.
REQ-029 Push 5 jobs back-to-back with DEPTH=4 while first active -> cmd_ready low only when 4 queued; done ids emerge in push order.
REQ-030 bn_valid on exact timeout cycle -> element counted, no TIMEOUT status.
REQ-031 Assert rst_n low during WAIT of job 2 of 3 -> all outputs 0 immediately, no done_valid, busy 0.
